// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for pipe_stage_reg instances: FSM states, counter
// saturation value and the ID/EX data-bus field layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

  // ID/EX data layout, LSB first; imm carries the raw 25 immediate bits of the
  // instruction so the whole record fits the 168-bit default data width.
  localparam int RD_LSB      = 0;
  localparam int RD_W        = 5;
  localparam int F3_LSB      = 5;
  localparam int F3_W        = 3;
  localparam int F7_LSB      = 8;
  localparam int F7_W        = 7;
  localparam int PC_LSB      = 15;
  localparam int PC4_LSB     = 47;
  localparam int RS1_LSB     = 79;
  localparam int RS2_LSB     = 111;
  localparam int XLEN        = 32;
  localparam int IMM_LSB     = 143;
  localparam int IMM_W       = 25;
  localparam int IDEX_DATA_W = 168;

  function automatic logic [RD_W-1:0] idex_rd(input logic [IDEX_DATA_W-1:0] d);
    return d[RD_LSB +: RD_W];
  endfunction

  function automatic logic [XLEN-1:0] idex_pc(input logic [IDEX_DATA_W-1:0] d);
    return d[PC_LSB +: XLEN];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] SAT = '1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != SAT)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, flush-to-bubble,
// optional two-entry skid buffer and bubble/stall performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = 11,
  parameter int DATA_W  = 168,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_t      state_reg;
  logic [CTRL_W-1:0] main_ctrl_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic [CTRL_W-1:0] skid_ctrl_reg;
  logic [DATA_W-1:0] skid_data_reg;

  logic accept_fire;
  logic release_fire;

  assign out_valid_o  = (state_reg != ST_EMPTY);
  assign out_ctrl_o   = out_valid_o ? main_ctrl_reg : '0;
  assign out_data_o   = main_data_reg;
  assign accept_fire  = in_valid_i & in_ready_o;
  assign release_fire = out_valid_o & out_ready_i;

  generate
    if (SKID_EN != 0) begin : g_skid_ready
      logic in_ready_reg;
      logic skid_next;

      // Ready is the registered image of "not going to SKID", so upstream
      // never sees a combinational path from out_ready_i.
      assign skid_next = ((state_reg == ST_SKID) && !release_fire) ||
                         ((state_reg == ST_FULL) && accept_fire && !release_fire);

      always_ff @(posedge clk) begin
        if (reset) begin
          in_ready_reg <= 1'b1;
        end else if (flush_i) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= !skid_next;
        end
      end

      assign in_ready_o = in_ready_reg;
    end else begin : g_comb_ready
      assign in_ready_o = ~out_valid_o | out_ready_i;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      main_data_reg <= '0;
      skid_ctrl_reg <= '0;
      skid_data_reg <= '0;
    end else if (flush_i) begin
      // Data is left in place; only validity and control are scrubbed.
      state_reg     <= ST_EMPTY;
      main_ctrl_reg <= '0;
      skid_ctrl_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept_fire) begin
            main_ctrl_reg <= in_ctrl_i;
            main_data_reg <= in_data_i;
            state_reg     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept_fire && release_fire) begin
            main_ctrl_reg <= in_ctrl_i;
            main_data_reg <= in_data_i;
          end else if (accept_fire && (SKID_EN != 0)) begin
            skid_ctrl_reg <= in_ctrl_i;
            skid_data_reg <= in_data_i;
            state_reg     <= ST_SKID;
          end else if (release_fire) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (release_fire) begin
            main_ctrl_reg <= skid_ctrl_reg;
            main_data_reg <= skid_data_reg;
            skid_ctrl_reg <= '0;
            state_reg     <= ST_FULL;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
        end
      endcase
    end
  end

  // Index 0 counts bubbles, index 1 counts stalls.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = ~out_valid_o;
  assign cnt_inc[1] = out_valid_o & ~out_ready_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .clear(reset),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign bubble_cnt_o = cnt_val[0];
  assign stall_cnt_o  = cnt_val[1];

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor of the fixed ID/EX latch: a generic pipeline stage register with valid/ready flow control, stall hold, flush-to-bubble and an optional two-entry skid buffer. Any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use it by setting widths. Control and data payloads are separate buses, so a bubble zeroes control (no reg_write, mem_write, branch, jalr) without touching data.

Parameters:
CTRL_W, 11, width of control payload; forced to zero whenever the stage holds a bubble
DATA_W, 168, width of data payload (pc, pc+4, rs1/rs2 data, immediate, funct3, funct7, rd)
SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single entry with combinational ready
CNT_W, 16, width of the bubble/stall performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
flush_i  input  1  discard all held entries and the current input beat
in_valid_i  input  1  upstream beat valid
in_ready_o  output  1  stage can accept a beat this cycle
in_ctrl_i  input  CTRL_W  upstream control payload
in_data_i  input  DATA_W  upstream data payload
out_valid_o  output  1  head entry valid
out_ready_i  input  1  downstream accepts head this cycle
out_ctrl_o  output  CTRL_W  head control; all zero when out_valid_o=0
out_data_o  output  DATA_W  head data; holds last value when out_valid_o=0
bubble_cnt_o  output  CNT_W  cycles with out_valid_o=0 since reset
stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0 since reset

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, skid entry invalid and zero, both counters 0, in_ready_o=1 from the first cycle after reset.
- Handshake: accept when in_valid_i&in_ready_o; release when out_valid_o&out_ready_i. Beats leave in order. None is duplicated or dropped except by flush.
- Latency: an accepted beat appears on out_* in the next cycle.
- SKID_EN=1, states:
  - EMPTY: main invalid.
  - FULL: main valid, skid invalid.
  - SKID: both valid.
- SKID_EN=1, transitions:
  - EMPTY: accept -> FULL.
  - FULL: accept and release -> FULL, main loads input. Accept with no release -> SKID, input goes to skid. Release with no accept -> EMPTY.
  - SKID: release -> FULL, main loads skid. No release -> hold.
- SKID_EN=1, in_ready_o: registered; equals (state != SKID). It must not depend combinationally on out_ready_i.
- SKID_EN=0: single entry. in_ready_o = ~out_valid_o | out_ready_i (combinational). Simultaneous accept and release loads the new beat with no bubble.
- Bubble: whenever out_valid_o=0, out_ctrl_o is driven 0 regardless of register contents. out_data_o is not cleared.
- Flush: on the next edge both entries become invalid, state becomes EMPTY, and ctrl is zeroed. An input beat presented in the flush cycle is discarded, even if in_ready_o=1. A release in the flush cycle still counts as completed downstream.
- Priority: reset > flush > normal operation.
- Counters: saturate at all-ones and do not wrap. The reset cycle is not counted. The flush cycle is counted by its pre-flush out_valid_o/out_ready_i values.
- Reset mid-operation: all held beats are lost. No output glitch beyond the reset values.

Decomposition:
- Shared package pipe_pkg: state enum {ST_EMPTY, ST_FULL, ST_SKID}; localparam for counter saturation value; ID/EX field offsets (funct3, funct7, rd, pc, pc4, rs1, rs2, imm) as constants so instances slice DATA_W consistently.
- One natural sub-module, sat_counter (width CNT_W, inc input, synchronous clear). It is instantiated twice, for the bubble and stall counters.

Test Plan:
- Reset then stream: hold reset=1 for 2 cycles, then in_valid_i=1 with ctrl=11'h7FF and data=1,2,3 on consecutive cycles, out_ready_i=1 -> out_data_o=1,2,3 one cycle later each; in_ready_o stays 1; bubble_cnt_o=1 after the first beat arrives.
- Backpressure with skid (SKID_EN=1): out_ready_i=0 while beats A=0xA, B=0xB are offered -> state SKID; in_ready_o=0 on the next cycle; C is held upstream. Raise out_ready_i -> outputs A, B, C in order with no loss; stall_cnt_o counts the stalled cycles.
- Flush: stage in SKID holding A, B; flush_i=1 while in_valid_i=1 with C -> next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; neither C nor B ever appears.
- Bubble control zeroing: after one beat with ctrl=11'h5A5 drains and no new input arrives -> out_ctrl_o=0 while out_data_o still equals the last data value.
- SKID_EN=0 with simultaneous accept and release: held beat X, out_ready_i=1, in_valid_i=1 with Y -> in_ready_o=1 combinationally; Y is on the output next cycle with no bubble.
- Counter saturation and mid-operation reset: CNT_W=4 with out_valid_o=0 for 20 cycles -> bubble_cnt_o stops at 4'hF. Then assert reset while in SKID -> everything returns to reset values on the next edge.
